// File: rtl/traffic_phase_controller_if.sv
// Timer handshake between the phase controller (master) and the interval timer (slave).
// The controller restarts the timer with an interval; the timer answers with an expiry pulse.
interface traffic_phase_controller_if;
  logic       Start_Timer;
  logic [3:0] Value;
  logic       Expired;

  modport master (output Start_Timer, output Value, input Expired);
  modport slave  (input Start_Timer, input Value, output Expired);
endinterface

// File: rtl/traffic_phase_controller.sv
// Moore phase sequencer for main/side street lights with a side-green extension and a
// pedestrian walk phase, paced by an external interval timer.
module traffic_phase_controller #(
  parameter logic [3:0] T_BASE = 4'd6,
  parameter logic [3:0] T_EXT  = 4'd3,
  parameter logic [3:0] T_YEL  = 4'd2,
  parameter logic [3:0] T_RED  = 4'd1
) (
  input  logic                          clock,
  input  logic                          Reset_N,
  input  logic                          Sensor,
  input  logic                          Walk_Request,
  traffic_phase_controller_if.master    tmr,
  output logic [2:0]                    Main_Light,
  output logic [2:0]                    Side_Light,
  output logic                          Walk,
  output logic [2:0]                    Phase
);

  typedef enum logic [2:0] {
    MAIN_GRN  = 3'd0,
    MAIN_YEL  = 3'd1,
    ALL_RED_A = 3'd2,
    SIDE_GRN  = 3'd3,
    SIDE_EXT  = 3'd4,
    SIDE_YEL  = 3'd5,
    ALL_RED_B = 3'd6,
    WALK      = 3'd7
  } phase_e;

  typedef struct packed {
    logic [3:0] value;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk;
  } decode_t;

  function automatic decode_t decode(input phase_e p);
    decode_t d;
    case (p)
      MAIN_GRN:  d = '{value: T_BASE, main_light: 3'b001, side_light: 3'b100, walk: 1'b0};
      MAIN_YEL:  d = '{value: T_YEL,  main_light: 3'b010, side_light: 3'b100, walk: 1'b0};
      ALL_RED_A: d = '{value: T_RED,  main_light: 3'b100, side_light: 3'b100, walk: 1'b0};
      SIDE_GRN:  d = '{value: T_BASE, main_light: 3'b100, side_light: 3'b001, walk: 1'b0};
      SIDE_EXT:  d = '{value: T_EXT,  main_light: 3'b100, side_light: 3'b001, walk: 1'b0};
      SIDE_YEL:  d = '{value: T_YEL,  main_light: 3'b100, side_light: 3'b010, walk: 1'b0};
      ALL_RED_B: d = '{value: T_RED,  main_light: 3'b100, side_light: 3'b100, walk: 1'b0};
      WALK:      d = '{value: T_EXT,  main_light: 3'b100, side_light: 3'b100, walk: 1'b1};
      default:   d = '{value: T_BASE, main_light: 3'b001, side_light: 3'b100, walk: 1'b0};
    endcase
    return d;
  endfunction

  phase_e  state_r;
  phase_e  next_s;
  logic    walk_pending_r;
  logic    start_r;
  logic    take_s;
  decode_t out_r;

  // An expiry arriving while the restart strobe is still high belongs to the previous phase.
  always_comb begin
    take_s = tmr.Expired && !start_r;
    next_s = state_r;
    if (take_s) begin
      case (state_r)
        MAIN_GRN:  next_s = (Sensor || walk_pending_r) ? MAIN_YEL : MAIN_GRN;
        MAIN_YEL:  next_s = ALL_RED_A;
        ALL_RED_A: next_s = SIDE_GRN;
        SIDE_GRN:  next_s = Sensor ? SIDE_EXT : SIDE_YEL;
        SIDE_EXT:  next_s = SIDE_YEL;
        SIDE_YEL:  next_s = ALL_RED_B;
        ALL_RED_B: next_s = walk_pending_r ? WALK : MAIN_GRN;
        WALK:      next_s = MAIN_GRN;
        default:   next_s = MAIN_GRN;
      endcase
    end else begin
      next_s = state_r;
    end
  end

  // State, walk latch, restart strobe and decoded outputs all update together.
  always_ff @(posedge clock or negedge Reset_N) begin
    if (!Reset_N) begin
      state_r        <= MAIN_GRN;
      walk_pending_r <= 1'b0;
      start_r        <= 1'b1;
      out_r          <= decode(MAIN_GRN);
    end else begin
      state_r <= next_s;
      start_r <= take_s;
      out_r   <= decode(next_s);
      if (take_s && (next_s == WALK)) begin
        walk_pending_r <= 1'b0;
      end else if (Walk_Request && (state_r != WALK)) begin
        walk_pending_r <= 1'b1;
      end else begin
        walk_pending_r <= walk_pending_r;
      end
    end
  end

  assign tmr.Start_Timer = start_r;
  assign tmr.Value       = out_r.value;
  assign Main_Light      = out_r.main_light;
  assign Side_Light      = out_r.side_light;
  assign Walk            = out_r.walk;
  assign Phase           = state_r;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Self-checking bench for traffic_phase_controller: directed table, timer-period run,
// randomized run against a phase model, and asynchronous reset mid SIDE_EXT.
module tb_traffic_phase_controller;

  logic       clock = 1'b0;
  logic       Reset_N = 1'b0;
  logic       Sensor = 1'b0;
  logic       Walk_Request = 1'b0;
  logic [2:0] Main_Light;
  logic [2:0] Side_Light;
  logic       Walk;
  logic [2:0] Phase;

  traffic_phase_controller_if tif ();

  traffic_phase_controller dut (
    .clock        (clock),
    .Reset_N      (Reset_N),
    .Sensor       (Sensor),
    .Walk_Request (Walk_Request),
    .tmr          (tif),
    .Main_Light   (Main_Light),
    .Side_Light   (Side_Light),
    .Walk         (Walk),
    .Phase        (Phase)
  );

  always #5 clock = ~clock;

  // Per-phase outputs straight from the phase table: value, {R,Y,G} main, {R,Y,G} side.
  logic [3:0] val_tab  [8] = '{4'd6, 4'd2, 4'd1, 4'd6, 4'd3, 4'd2, 4'd1, 4'd3};
  logic [2:0] main_tab [8] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] side_tab [8] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b001, 3'b010, 3'b100, 3'b100};
  int         succ     [8] = '{0, 2, 3, 5, 5, 6, 0, 0};

  int vectors = 0;
  int miscompares = 0;

  // Reference model state.
  int m_phase = 0;
  bit m_pend  = 1'b0;
  bit m_start = 1'b1;

  typedef struct {
    logic s;
    logic r;
    logic e;
    int   ph;
    logic st;
  } vec_t;
  vec_t tbl [20];

  task automatic check(input string name, input int ph, input logic st);
    logic [2:0] ph3;
    logic       wexp;
    ph3  = ph[2:0];
    wexp = (ph == 7);
    vectors++;
    if (Phase !== ph3 || tif.Start_Timer !== st || tif.Value !== val_tab[ph] ||
        Main_Light !== main_tab[ph] || Side_Light !== side_tab[ph] || Walk !== wexp) begin
      miscompares++;
      $display("FAIL %s: got phase=%0d start=%b value=%0d main=%b side=%b walk=%b, want phase=%0d start=%b value=%0d main=%b side=%b walk=%b",
               name, Phase, tif.Start_Timer, tif.Value, Main_Light, Side_Light, Walk,
               ph, st, val_tab[ph], main_tab[ph], side_tab[ph], wexp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_pend  = 1'b0;
    m_start = 1'b1;
  endtask

  // Apply inputs, advance the model by one clock, then clock the DUT and settle.
  task automatic tick(input logic s, input logic r, input logic e);
    bit take;
    int nxt;
    Sensor       = s;
    Walk_Request = r;
    tif.Expired  = e;
    take = e && !m_start;
    nxt  = m_phase;
    if (take) begin
      nxt = succ[m_phase];
      if (m_phase == 0 && (s || m_pend)) nxt = 1;
      if (m_phase == 3 && s)             nxt = 4;
      if (m_phase == 6 && m_pend)        nxt = 7;
    end
    if (take && nxt == 7)          m_pend = 1'b0;
    else if (r && m_phase != 7)    m_pend = 1'b1;
    m_start = take;
    m_phase = nxt;
    @(posedge clock);
    #1;
  endtask

  initial begin
    bit reached;
    // {Sensor, Walk_Request, Expired, expected phase, expected Start_Timer}
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 0, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 2, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 2, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 3, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 3, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 4, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 4, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 5, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 5, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 6, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 6, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 7, 1'b1};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 7, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 1'b1, 0, 1'b1};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 0, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 1'b1, 0, 1'b1};

    tif.Expired = 1'b0;
    model_reset();
    #12;
    check("reset", 0, 1'b1);
    Reset_N = 1'b1;

    foreach (tbl[i]) begin
      tick(tbl[i].s, tbl[i].r, tbl[i].e);
      check($sformatf("table[%0d]", i), tbl[i].ph, tbl[i].st);
    end

    // Timer emulation: Expired 10 cycles after each Start_Timer, no demand.
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 10; j++) begin
        tick(1'b0, 1'b0, 1'b0);
        check("period_idle", m_phase, m_start);
      end
      tick(1'b0, 1'b0, 1'b1);
      check("period_restart", 0, 1'b1);
    end

    for (int n = 0; n < 2000; n++) begin
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 3) == 0));
      check("random", m_phase, m_start);
    end

    reached = 1'b0;
    for (int n = 0; n < 100 && !reached; n++) begin
      tick(1'b1, 1'b0, !m_start);
      check("to_side_ext", m_phase, m_start);
      if (m_phase == 4 && !m_start) reached = 1'b1;
    end
    vectors++;
    if (!reached) begin
      miscompares++;
      $display("FAIL reach_side_ext: got phase=%0d, want phase=4 within 100 cycles", Phase);
    end

    #2;
    Reset_N = 1'b0;
    model_reset();
    #1;
    check("async_reset", 0, 1'b1);
    @(posedge clock);
    #1;
    check("reset_held", 0, 1'b1);
    #2;
    Reset_N = 1'b1;
    #1;
    check("reset_release", 0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    check("first_edge", 0, 1'b0);
    tick(1'b1, 1'b0, 1'b1);
    check("after_reset_go", 1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
